score_keeper: RTL and testbench

Game-state and scoring stage directly downstream of the hit detector. It consumes the detector's `hit` level and the sprite mover's wrap pulse, and keeps score, lives and difficulty level. It runs the IDLE/PLAY/OVER game state machine and supplies a stable binary score and a 3-digit BCD score to the graphics block. The `level` output feeds back to the sprite mover for speed selection.

---
 rtl/game_pkg.sv | 15 +
 rtl/bin2bcd_seq.sv | 36 +++
 rtl/score_keeper.sv | 86 ++++++++
 tb/tb_score_keeper.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game state encoding, default game parameters, screen constants
// and the double-dabble digit adjust used by the BCD converter.
package game_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  localparam int DEF_LIVES      = 3;
  localparam int DEF_LEVEL_STEP = 8;
  localparam int DEF_MAX_LEVEL  = 9;
  localparam int X_SPAWN        = 160;
  function automatic logic [11:0] dabble(input logic [11:0] d);
    logic [11:0] r;
    for (int i = 0; i < 3; i++)
      r[4*i+:4] = (d[4*i+:4] >= 4'd5) ? d[4*i+:4] + 4'd3 : d[4*i+:4];
    return r;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble, one shift per cycle.
// Ports: clk, rst (async, active-high), start (capture bin when idle), bin,
// busy (conversion in flight), done (result valid this cycle), bcd (3 digits).
module bin2bcd_seq import game_pkg::*; #(
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [11:0]        bcd
);
  localparam int CW = $clog2(SCORE_W + 1);
  logic [11+SCORE_W:0] sr;
  logic [CW-1:0]       cnt;
  assign done = busy && cnt == '0;
  assign bcd  = sr[SCORE_W+:12];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start && !busy) begin
      sr   <= {12'd0, bin};
      cnt  <= CW'(SCORE_W);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        sr  <= {dabble(sr[SCORE_W+:12]), sr[SCORE_W-1:0]} << 1;
        cnt <= cnt - 1'b1;
      end else
        busy <= 1'b0;
    end
endmodule

// File: rtl/score_keeper.sv
// score_keeper: game FSM (IDLE/PLAY/OVER), score/lives/level keeping and BCD score.
// Ports: CLOCK_50, reset (async, active-high), start/hit (levels, rise-detected),
// wrap (end-of-pass pulse); score, score_bcd, lives, level, playing, game_over.
module score_keeper import game_pkg::*; #(
  parameter int LIVES      = DEF_LIVES,
  parameter int LEVEL_STEP = DEF_LEVEL_STEP,
  parameter int MAX_LEVEL  = DEF_MAX_LEVEL,
  parameter int SCORE_W    = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               hit,
  input  logic               wrap,
  output logic [SCORE_W-1:0] score,
  output logic [11:0]        score_bcd,
  output logic [1:0]         lives,
  output logic [3:0]         level,
  output logic               playing,
  output logic               game_over
);
  localparam int SW = $clog2(LEVEL_STEP + 1);
  state_t             state;
  logic               hit_q, start_q, hit_seen, busy, done;
  logic [SW-1:0]      step;
  logic [SCORE_W-1:0] conv_val;
  logic [11:0]        bcd;
  logic               hit_rise, start_rise, counted, miss, conv_go, level_up;
  assign hit_rise   = hit & ~hit_q;
  assign start_rise = start & ~start_q;
  assign counted    = state == PLAY && hit_rise && !hit_seen;
  // a hit in the same cycle as wrap belongs to the ending pass, so it prevents the miss
  assign miss       = state == PLAY && wrap && !hit_seen && !hit_rise;
  assign level_up   = step == SW'(LEVEL_STEP - 1);
  assign conv_go    = !busy && score != conv_val;
  bin2bcd_seq #(.SCORE_W(SCORE_W)) u_bcd (
    .clk(CLOCK_50), .rst(reset), .start(conv_go), .bin(score),
    .busy(busy), .done(done), .bcd(bcd)
  );
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state     <= IDLE;
      hit_q     <= 1'b0;
      start_q   <= 1'b0;
      hit_seen  <= 1'b0;
      step      <= '0;
      score     <= '0;
      lives     <= 2'(LIVES);
      level     <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      conv_val  <= '0;
      score_bcd <= '0;
    end else begin
      hit_q   <= hit;
      start_q <= start;
      if (conv_go) conv_val <= score;
      // a result whose source value has since changed is stale and dropped
      if (done && conv_val == score) score_bcd <= bcd;
      if (state != PLAY && start_rise) begin
        state     <= PLAY;
        playing   <= 1'b1;
        game_over <= 1'b0;
        score     <= '0;
        level     <= '0;
        lives     <= 2'(LIVES);
        hit_seen  <= 1'b0;
        step      <= '0;
      end
      if (counted) begin
        hit_seen <= 1'b1;
        score    <= &score ? score : score + 1'b1;
        step     <= level_up ? '0 : step + 1'b1;
        if (level_up && level != 4'(MAX_LEVEL)) level <= level + 1'b1;
      end
      if (state == PLAY && wrap) hit_seen <= 1'b0;
      if (miss) begin
        lives <= lives - 1'b1;
        if (lives == 2'd1) begin
          state     <= OVER;
          playing   <= 1'b0;
          game_over <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed and random stimulus against a behavioural game model.
module tb_score_keeper;
  localparam int W  = 8;
  localparam int NL = 3;
  logic         CLOCK_50 = 1'b0, reset = 1'b1, start = 1'b0, hit = 1'b0, wrap = 1'b0;
  logic [W-1:0] score;
  logic [11:0]  score_bcd;
  logic [1:0]   lives;
  logic [3:0]   level;
  logic         playing, game_over;
  int checks = 0, errors = 0;
  int m_state = 0, m_score = 0, m_lives = NL, m_hits = 0, m_stable = 1000;
  bit m_seen = 0, m_hq = 0, m_sq = 0;

  score_keeper dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .hit(hit), .wrap(wrap),
    .score(score), .score_bcd(score_bcd), .lives(lives), .level(level),
    .playing(playing), .game_over(game_over)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction

  // model: game rules as plain arithmetic; level derives from total counted hits
  always @(posedge CLOCK_50 or posedge reset) begin
    int  old;
    bit  hr, sr;
    if (reset) begin
      m_state = 0; m_score = 0; m_lives = NL; m_hits = 0;
      m_seen = 0; m_hq = 0; m_sq = 0; m_stable = 1000;
    end else begin
      hr = hit && !m_hq;
      sr = start && !m_sq;
      m_hq = hit;
      m_sq = start;
      old = m_score;
      if (m_state != 1) begin
        if (sr) begin
          m_state = 1; m_score = 0; m_lives = NL; m_hits = 0; m_seen = 0;
        end
      end else begin
        if (hr && !m_seen) begin
          m_seen = 1;
          m_hits++;
          if (m_score < 255) m_score++;
        end
        if (wrap) begin
          if (!m_seen) begin
            m_lives--;
            if (m_lives == 0) m_state = 2;
          end
          m_seen = 0;
        end
      end
      m_stable = (m_score != old) ? 0 : m_stable + 1;
    end
  end

  always @(negedge CLOCK_50) begin
    chk("score", score, m_score);
    chk("lives", lives, m_lives);
    chk("level", level, (m_hits / 8 > 9) ? 9 : m_hits / 8);
    chk("playing", playing, m_state == 1);
    chk("game_over", game_over, m_state == 2);
    if (m_stable >= 2 * W + 4) chk("score_bcd", score_bcd, to_bcd(m_score));
  end

  task automatic drive(input logic h, input logic w, input logic s);
    @(negedge CLOCK_50);
    hit = h; wrap = w; start = s;
  endtask

  initial begin
    repeat (3) drive(0, 0, 0);
    reset = 1'b0;
    drive(1, 0, 0); drive(0, 1, 0); drive(1, 1, 0); drive(0, 0, 0); drive(0, 0, 0);
    chk("pre_score", score, 0);
    chk("pre_playing", playing, 0);
    chk("pre_lives", lives, 3);
    drive(0, 0, 1); drive(0, 0, 0);
    chk("start_playing", playing, 1);
    chk("start_lives", lives, 3);
    chk("start_score", score, 0);
    repeat (2) begin
      drive(1, 0, 0); drive(0, 0, 0); drive(0, 1, 0); drive(0, 0, 0);
    end
    repeat (30) drive(0, 0, 0);
    chk("bcd_two", score_bcd, 'h002);
    drive(1, 0, 0);
    repeat (10) @(posedge CLOCK_50);
    #1 chk("bcd_lat9", score_bcd, 'h002);
    @(posedge CLOCK_50);
    #1 chk("bcd_lat10", score_bcd, 'h003);
    chk("three_score", score, 3);
    drive(0, 0, 0); drive(0, 1, 0); drive(0, 0, 0);
    chk("three_lives", lives, 3);
    drive(1, 0, 0); drive(0, 0, 0); drive(1, 0, 0); drive(0, 0, 0); drive(0, 1, 0); drive(0, 0, 0);
    chk("double_hit", score, 4);
    drive(0, 1, 0); drive(0, 0, 0);
    chk("miss_lives", lives, 2);
    drive(1, 1, 0); drive(0, 0, 0);
    chk("same_cyc_score", score, 5);
    chk("same_cyc_lives", lives, 2);
    drive(0, 1, 0); drive(0, 0, 0);
    chk("after_same_lives", lives, 1);
    repeat (3) begin
      drive(0, 1, 0); drive(0, 0, 0);
    end
    chk("over_lives", lives, 0);
    chk("over_flag", game_over, 1);
    chk("over_playing", playing, 0);
    drive(1, 0, 0); drive(0, 0, 0);
    chk("over_hold_score", score, 5);
    drive(0, 0, 1); drive(0, 0, 0);
    chk("restart_playing", playing, 1);
    chk("restart_score", score, 0);
    chk("restart_lives", lives, 3);
    repeat (256) begin
      drive(1, 0, 0); drive(0, 1, 0);
    end
    drive(0, 0, 0);
    chk("sat_score", score, 255);
    chk("sat_level", level, 9);
    repeat (25) drive(0, 0, 0);
    chk("sat_bcd", score_bcd, 'h255);
    repeat (3) begin
      drive(0, 1, 0); drive(0, 0, 0);
    end
    drive(0, 0, 1); drive(0, 0, 0);
    repeat (3) @(posedge CLOCK_50);
    #2 reset = 1'b1;
    #1;
    chk("rst_score", score, 0);
    chk("rst_bcd", score_bcd, 0);
    chk("rst_lives", lives, NL);
    chk("rst_level", level, 0);
    chk("rst_playing", playing, 0);
    chk("rst_over", game_over, 0);
    drive(0, 0, 0); drive(0, 0, 0);
    reset = 1'b0;
    repeat (3000)
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);
    repeat (30) drive(0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
